// File: rtl/simple_processor.sv
// simple_processor: button-stepped 4-bit teaching processor (8-word ROM, 8x4 RF, 16x4 DM).
// Define SIMPLE_PROCESSOR_SEG_EN to build the refresh counter and seven-segment driver.
module simple_processor #(
   parameter int REFRESH_BITS = 18
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        leftBtn,
   input  logic        rightBtn,
   input  logic        switchEn,
   input  logic [11:0] switch,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [3:0]  an,
   output logic [3:0]  Res,
   output logic [3:0]  rdd1
);

   localparam logic [2:0] OP_ST  = 3'b000;
   localparam logic [2:0] OP_LD  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_LDI = 3'b100;

   // Fixed demonstration program; unused slots are NOPs.
   function automatic logic [11:0] rom_word(input logic [2:0] addr);
      logic [11:0] w;
      case (addr)
         3'd0:    w = 12'h831;
         3'd1:    w = 12'h852;
         3'd2:    w = 12'h4CA;
         3'd3:    w = 12'h023;
         3'd4:    w = 12'h224;
         3'd5:    w = 12'h761;
         3'd6:    w = 12'hE00;
         3'd7:    w = 12'hE00;
         default: w = 12'hE00;
      endcase
      return w;
   endfunction

   // Hex font, active-low, bit 0 = segment a ... bit 6 = segment g.
   function automatic logic [6:0] hex_seg(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0:    s = 7'h40;
         4'h1:    s = 7'h79;
         4'h2:    s = 7'h24;
         4'h3:    s = 7'h30;
         4'h4:    s = 7'h19;
         4'h5:    s = 7'h12;
         4'h6:    s = 7'h02;
         4'h7:    s = 7'h78;
         4'h8:    s = 7'h00;
         4'h9:    s = 7'h10;
         4'hA:    s = 7'h08;
         4'hB:    s = 7'h03;
         4'hC:    s = 7'h46;
         4'hD:    s = 7'h21;
         4'hE:    s = 7'h06;
         4'hF:    s = 7'h0E;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   logic [2:0]  pc_r;
   logic [3:0]  res_r;
   logic [3:0]  rf_r [8];
   logic [3:0]  dm_r [16];
   logic        lq_r;
   logic        rq_r;

   logic        exec_s;
   logic        restart_s;
   logic [11:0] instr_s;
   logic [2:0]  op_s;
   logic [2:0]  d_s;
   logic [2:0]  a_s;
   logic [2:0]  b_s;
   logic [3:0]  k_s;
   logic [2:0]  r_s;
   logic [3:0]  rd1_s;
   logic [3:0]  rd2_s;
   logic        rf_we_s;
   logic [2:0]  rf_wa_s;
   logic [3:0]  rf_wd_s;
   logic        dm_we_s;
   logic        res_we_s;
   logic [3:0]  res_wd_s;

   // An X on a button input yields an X pulse, which the if-conditions below treat as no edge.
   assign exec_s    = leftBtn & ~lq_r;
   assign restart_s = rightBtn & ~rq_r;

   // Instruction select and field decode.
   always_comb begin
      instr_s = switchEn ? switch : rom_word(pc_r);
      op_s    = instr_s[11:9];
      d_s     = instr_s[8:6];
      a_s     = instr_s[5:3];
      b_s     = instr_s[2:0];
      k_s     = instr_s[7:4];
      r_s     = instr_s[2:0];
   end

   // Register-file read ports; port 1 follows a for ALU ops and r otherwise.
   always_comb begin
      rd2_s = rf_r[b_s];
      if ((op_s == OP_ADD) || (op_s == OP_SUB)) begin
         rd1_s = rf_r[a_s];
      end else begin
         rd1_s = rf_r[r_s];
      end
   end

   assign rdd1 = rd1_s;

   // Execute: write enables and write data for RF, DM and Res.
   always_comb begin
      rf_we_s  = 1'b0;
      rf_wa_s  = r_s;
      rf_wd_s  = 4'h0;
      dm_we_s  = 1'b0;
      res_we_s = 1'b0;
      res_wd_s = res_r;
      if (exec_s) begin
         case (op_s)
            OP_ST: begin
               dm_we_s  = 1'b1;
               res_we_s = 1'b1;
               res_wd_s = rd1_s;
            end
            OP_LD: begin
               rf_we_s  = 1'b1;
               rf_wd_s  = dm_r[k_s];
               res_we_s = 1'b1;
               res_wd_s = dm_r[k_s];
            end
            OP_ADD: begin
               rf_we_s  = 1'b1;
               rf_wa_s  = d_s;
               rf_wd_s  = rd1_s + rd2_s;
               res_we_s = 1'b1;
               res_wd_s = rd1_s + rd2_s;
            end
            OP_SUB: begin
               rf_we_s  = 1'b1;
               rf_wa_s  = d_s;
               rf_wd_s  = rd1_s - rd2_s;
               res_we_s = 1'b1;
               res_wd_s = rd1_s - rd2_s;
            end
            OP_LDI: begin
               rf_we_s  = 1'b1;
               rf_wd_s  = k_s;
               res_we_s = 1'b1;
               res_wd_s = k_s;
            end
            default: begin
               rf_we_s  = 1'b0;
               res_we_s = 1'b0;
            end
         endcase
      end else begin
         rf_we_s  = 1'b0;
         dm_we_s  = 1'b0;
         res_we_s = 1'b0;
      end
   end

   // Architectural state: button edge flops, PC, Res, RF and DM.
   always_ff @(posedge clk) begin
      if (reset) begin
         lq_r  <= 1'b0;
         rq_r  <= 1'b0;
         pc_r  <= 3'd0;
         res_r <= 4'h0;
         for (int i = 0; i < 8; i++) begin
            rf_r[i] <= 4'h0;
         end
         for (int i = 0; i < 16; i++) begin
            dm_r[i] <= 4'h0;
         end
      end else begin
         lq_r <= leftBtn;
         rq_r <= rightBtn;
         if (rf_we_s) begin
            rf_r[rf_wa_s] <= rf_wd_s;
         end
         if (dm_we_s) begin
            dm_r[k_s] <= rd1_s;
         end
         if (res_we_s) begin
            res_r <= res_wd_s;
         end
         // Restart takes priority over the post-execute increment.
         if (restart_s) begin
            pc_r <= 3'd0;
         end else if (exec_s && !switchEn) begin
            pc_r <= pc_r + 3'd1;
         end
      end
   end

   assign Res = res_r;
   assign dp  = 1'b1;

`ifdef SIMPLE_PROCESSOR_SEG_EN
   logic [REFRESH_BITS-1:0] refresh_r;
   logic [1:0]              digit_sel_s;
   logic [3:0]              digit_val_s;
   logic [6:0]              seg_r;
   logic [3:0]              an_r;

   assign digit_sel_s = refresh_r[REFRESH_BITS-1 -: 2];

   // Digit multiplexer: PC, Res, rdd1, op from left to right.
   always_comb begin
      case (digit_sel_s)
         2'd3:    digit_val_s = {1'b0, pc_r};
         2'd2:    digit_val_s = res_r;
         2'd1:    digit_val_s = rd1_s;
         2'd0:    digit_val_s = {1'b0, op_s};
         default: digit_val_s = 4'h0;
      endcase
   end

   // Refresh counter and registered segment/anode drive.
   always_ff @(posedge clk) begin
      if (reset) begin
         refresh_r <= {REFRESH_BITS{1'b0}};
         seg_r     <= 7'h7F;
         an_r      <= 4'hF;
      end else begin
         refresh_r <= refresh_r + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
         seg_r     <= hex_seg(digit_val_s);
         an_r      <= ~(4'b0001 << digit_sel_s);
      end
   end

   assign seg = seg_r;
   assign an  = an_r;
`else
   assign seg = 7'h7F;
   assign an  = 4'hF;
`endif

endmodule

// File: tb/tb_simple_processor.sv
// Directed bench for simple_processor: ROM program, held button, switch mode, restart and reset.
module tb_simple_processor;

   logic        clk;
   logic        reset;
   logic        leftBtn;
   logic        rightBtn;
   logic        switchEn;
   logic [11:0] switch;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic [3:0]  Res;
   logic [3:0]  rdd1;

   int vectors;
   int miscompares;

   simple_processor dut (
      .clk      (clk),
      .reset    (reset),
      .leftBtn  (leftBtn),
      .rightBtn (rightBtn),
      .switchEn (switchEn),
      .switch   (switch),
      .seg      (seg),
      .dp       (dp),
      .an       (an),
      .Res      (Res),
      .rdd1     (rdd1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [6:0] observed, input logic [6:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // One-cycle leftBtn pulse; returns at the negedge after the executing posedge.
   task automatic pulse_left();
      @(negedge clk);
      leftBtn = 1'b1;
      @(negedge clk);
      leftBtn = 1'b0;
      #1;
   endtask

   task automatic pulse_right();
      @(negedge clk);
      rightBtn = 1'b1;
      @(negedge clk);
      rightBtn = 1'b0;
      #1;
   endtask

   task automatic set_switch(input logic [11:0] w);
      @(negedge clk);
      switch = w;
      #1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      // Buttons stay X while reset is held.
      reset    = 1'b1;
      switchEn = 1'b0;
      switch   = 12'h000;
      repeat (3) @(negedge clk);
      leftBtn  = 1'b0;
      rightBtn = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("reset_res", {3'b0, Res}, 7'h00);
      check("reset_rdd1", {3'b0, rdd1}, 7'h00);
      check("dp_high", {6'b0, dp}, 7'h01);
`ifndef SIMPLE_PROCESSOR_SEG_EN
      check("seg_off", seg, 7'h7F);
      check("an_off", {3'b0, an}, 7'h0F);
`endif

      // ROM program steps 0..5
      pulse_left();
      check("p0_ldi_res", {3'b0, Res}, 7'h03);
      check("p0_rdd1_r2", {3'b0, rdd1}, 7'h00);
      pulse_left();
      check("p1_ldi_res", {3'b0, Res}, 7'h05);
      check("p1_rdd1_r1", {3'b0, rdd1}, 7'h03);
      pulse_left();
      check("p2_add_res", {3'b0, Res}, 7'h08);
      check("p2_rdd1_r3", {3'b0, rdd1}, 7'h08);
      pulse_left();
      check("p3_st_res", {3'b0, Res}, 7'h08);
      check("p3_rdd1_r4", {3'b0, rdd1}, 7'h00);
      pulse_left();
      check("p4_ld_res", {3'b0, Res}, 7'h08);
      check("p4_rdd1_r4", {3'b0, rdd1}, 7'h08);
      pulse_left();
      check("p5_sub_res", {3'b0, Res}, 7'h05);
      check("p5_rdd1_r0", {3'b0, rdd1}, 7'h00);

      // Held button at PC=6: exactly one NOP, PC -> 7
      @(negedge clk);
      leftBtn = 1'b1;
      repeat (5) @(negedge clk);
      leftBtn = 1'b0;
      #1;
      check("hold_res", {3'b0, Res}, 7'h05);
      pulse_left();
      check("wrap_rdd1_r1", {3'b0, rdd1}, 7'h03);
      check("wrap_res", {3'b0, Res}, 7'h05);

      // Switch mode: inspect RF, load DM, LDI and self-add
      switchEn = 1'b1;
      set_switch(12'hE05);
      check("rf5", {3'b0, rdd1}, 7'h05);
      set_switch(12'hE04);
      check("rf4", {3'b0, rdd1}, 7'h08);
      set_switch(12'h226);
      pulse_left();
      check("sw_ld_dm2", {3'b0, Res}, 7'h08);
      set_switch(12'h8F7);
      pulse_left();
      check("sw_ldi_res", {3'b0, Res}, 7'h0F);
      set_switch(12'hE07);
      check("sw_rf7", {3'b0, rdd1}, 7'h0F);
      set_switch(12'h5FF);
      check("sw_add_rdd1", {3'b0, rdd1}, 7'h0F);
      pulse_left();
      check("sw_add_res", {3'b0, Res}, 7'h0E);
      set_switch(12'hE00);
      pulse_left();
      check("sw_nop_res", {3'b0, Res}, 7'h0E);
      @(negedge clk);
      switchEn = 1'b0;
      #1;
      check("pc_kept_0", {3'b0, rdd1}, 7'h03);

      // Advance to PC=5 then restart
      repeat (5) pulse_left();
      check("pc5_res", {3'b0, Res}, 7'h08);
      check("pc5_rdd1", {3'b0, rdd1}, 7'h08);
      pulse_right();
      check("restart_rdd1", {3'b0, rdd1}, 7'h03);
      check("restart_res", {3'b0, Res}, 7'h08);
      pulse_left();
      check("rerun_ldi", {3'b0, Res}, 7'h03);
      pulse_left();
      check("rerun_ldi2", {3'b0, Res}, 7'h05);

      // Both buttons at PC=2: ADD executes, PC restarts
      @(negedge clk);
      leftBtn  = 1'b1;
      rightBtn = 1'b1;
      @(negedge clk);
      leftBtn  = 1'b0;
      rightBtn = 1'b0;
      #1;
      check("both_res", {3'b0, Res}, 7'h08);
      check("both_pc0", {3'b0, rdd1}, 7'h03);

      // Reset wins over a simultaneous leftBtn edge
      @(negedge clk);
      leftBtn = 1'b1;
      reset   = 1'b1;
      @(negedge clk);
      leftBtn = 1'b0;
      reset   = 1'b0;
      #1;
      check("rst_res", {3'b0, Res}, 7'h00);
      check("rst_rf1", {3'b0, rdd1}, 7'h00);
      switchEn = 1'b1;
      set_switch(12'hE03);
      check("rst_rf3", {3'b0, rdd1}, 7'h00);
      set_switch(12'h226);
      pulse_left();
      check("rst_dm2", {3'b0, Res}, 7'h00);
      @(negedge clk);
      switchEn = 1'b0;
      #1;
      pulse_left();
      check("rst_pc0", {3'b0, Res}, 7'h03);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/simple_processor.md
# simple_processor

Single-cycle, button-stepped 4-bit teaching processor for the FPGA board top level. Each debounced-free rising edge of `leftBtn` executes one 12-bit instruction, fetched from an internal 8-word program ROM or, when `switchEn` is high, taken from the board switches. It owns an 8×4 register file and a 16×4 data memory. It exposes the last result and register read port 1, and drives a 4-digit seven-segment display.

## Interface
Parameters:
- `REFRESH_BITS`, 18: width of the display refresh counter; the top 2 bits select the digit.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high. Sampled on `posedge clk`.
- `leftBtn` in 1: step button; its rising edge executes one instruction.
- `rightBtn` in 1: its rising edge restarts the program (PC←0). Registers and memory are left unchanged.
- `switchEn` in 1: 1 = execute the `switch` word; 0 = execute `ROM[PC]`.
- `switch` in 12: manual instruction word.
- `seg` out 7: active-low segments, `seg[0]`=a … `seg[6]`=g.
- `dp` out 1: decimal point, active-low. Held at 1.
- `an` out 4: active-low digit enables.
- `Res` out 4: value written by the last executed instruction.
- `rdd1` out 4: combinational RF read port 1 for the currently selected instruction.

## Operation
- Instruction fields: `op=[11:9]`. ALU form: `d=[8:6]`, `a=[5:3]`, `b=[2:0]`. Mem/imm form: `k=[7:4]`, `r=[2:0]`. Bits 8 and 3 are ignored in mem/imm form.
- Opcodes:
  - 000 ST: `DM[k]←RF[r]`; Res←RF[r].
  - 001 LD: `RF[r]←DM[k]`; Res←DM[k].
  - 010 ADD: `RF[d]←(RF[a]+RF[b]) mod 16`; Res←sum.
  - 011 SUB: `RF[d]←(RF[a]−RF[b]) mod 16`; Res←difference.
  - 100 LDI: `RF[r]←k`; Res←k.
  - 101/110/111 NOP: no state change; Res holds.
- `rdd1` = RF[a] for ADD/SUB, RF[r] for all other opcodes. It is combinational from the current instruction.
- PC is 3 bits. It increments (wrapping 7→0) only when a ROM instruction executes. Switch-sourced execution leaves PC unchanged.
- ROM contents, fixed:
  - 0: `12'h831` LDI R1,3
  - 1: `12'h852` LDI R2,5
  - 2: `12'h4CA` ADD R3,R1,R2
  - 3: `12'h023` ST M2,R3
  - 4: `12'h224` LD R4,M2
  - 5: `12'h761` SUB R5,R4,R1
  - 6–7: `12'hE00` NOP
- Display digits:
  - an[3]: PC, shown as 0–7.
  - an[2]: Res.
  - an[1]: rdd1.
  - an[0]: op.
  - All digits use a hex 0–F font.
- Reset clears PC, Res, all RF and DM entries, the button edge flops and the refresh counter.

## Timing
- Edge detection: each button is registered into `q`. The exec pulse is `btn & ~q`, evaluated at the same edge.
- The instruction executes on the posedge at which the button is sampled 1 while `q`=0. RF, DM, PC and Res update at that edge, so results are visible one cycle later.
- A button held high executes once. A 1-cycle high pulse is enough.
- `leftBtn` and `rightBtn` edges on the same cycle: the instruction executes, then PC←0. Restart wins over increment.
- `reset` high overrides everything, including a simultaneous button edge.
- Register read-after-write within one instruction (e.g. ADD R1,R1,R1) reads the old value.
- Button inputs at X/unknown before the first edge must not corrupt state after reset. Treat X as no edge. The simulation-safe requirement is that `q` resets to 0.
- The seven-segment digit advances every 2^(REFRESH_BITS−2) cycles.

## Configuration
- `SIMPLE_PROCESSOR_SEG_EN` defined: refresh counter and seven-segment driver are instantiated as above.
- Not defined: no refresh counter. `seg`=7'h7F, `an`=4'hF, `dp`=1 constantly. All processor behaviour is unchanged.

## Test plan
- Reset, `switchEn`=0, three `leftBtn` pulses → Res = 3, 5, 8; PC = 3; `rdd1` after the third pulse = RF[3] = 8 (ST selects r=3).
- Continue three more pulses → DM[2]=8; Res = 8, 8, 5; RF[4]=8; RF[5]=5.
- Hold `leftBtn` high for 5 cycles → exactly one execution; PC advances by 1.
- `switchEn`=1, `switch`=`12'h8F7` (LDI R7,15), pulse → RF[7]=15, Res=15, PC unchanged. Then `switch`=`12'h5FF` (ADD R7,R7,R7), pulse → Res=14.
- At PC=5, pulse `rightBtn` → PC=0, RF retained. The next `leftBtn` re-executes LDI R1,3 → Res=3.
- Assert `reset` concurrently with a `leftBtn` edge → PC=0, Res=0, RF[1]=0.
